conv2d_engine: RTL and testbench
================================

// Module: conv2d_engine
// PURPOSE
//  Parametrised 2-D convolution engine: next generation of the fixed 3x3 convolution FSM.
//  Reads image size and kernel size (odd, 1..KMAX) from a parameter block in shared memory.
//  Caches the kernel in a local register file, then streams image reads and writes outputs.
//  Accumulates wide, with right-shift and saturation. Same single-port bus as the other compute FSMs.
// PARAMETERS
//  DATA_W      32  data word width; signed two's complement
//  ADDR_W      32  bus address width
//  KMAX        5   largest supported kernel dimension (odd); kernel cache is KMAX*KMAX words
//  ACC_W       72  accumulator width; must be >= 2*DATA_W + 8
//  PARAM_BASE  0   word address of the parameter block
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse; accepted only when busy==0
//  abort          in   1       level; ends any operation, returns to IDLE
//  mem_opdone     in   1       bus: current transfer complete, sampled at posedge
//  data_i         in   DATA_W  bus read data; valid when mem_opdone==1 on a read
//  data_o         out  DATA_W  bus write data
//  addr_o         out  ADDR_W  bus word address
//  mem_operation  out  2       bus op: 00 none, 01 read, 11 write
//  busy           out  1       high from start accept until DONE/ERR/abort
//  done           out  1       1-cycle pulse at the end of a run, with or without error
//  error          out  1       sticky until the next accepted start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accumulator and kernel cache cleared.
//  Async assert takes effect mid-transfer with no completion.
//  Memory map (word addresses, P=PARAM_BASE):
//    P+1 W (image width); P+2 H (image height); P+3 K (kernel size); P+4 S (shift, 0..63).
//    A = P+6 (row-major image); KB = A+W*H (kernel, KxK); C = KB+K*K (output, row-major).
//  Bus handshake:
//    - Drive addr_o, mem_operation (and data_o on writes); hold them stable until mem_opdone==1 at a posedge.
//    - Next cycle mem_operation=00 (one idle cycle minimum).
//    - mem_opdone is ignored while mem_operation==00. No timeout.
//  FSM:
//    IDLE     -start-> PARAM_RD; clears error, sets busy.
//    PARAM_RD reads P+1..P+4 in order, then -> CHECK.
//    CHECK    (1 cycle) -> ERR if K even, K==0, K>KMAX, W==0, H==0, or (valid mode) K>W or K>H;
//             otherwise -> KERN_LD.
//    KERN_LD  reads K*K words from KB into cache[ky*K+kx]; -> PIX_RD.
//    PIX_RD   for output (oy,ox), taps ky,kx 0..K-1, kx fastest:
//             acc += A[iy][ix] * cache[ky*K+kx], accumulated on the opdone cycle.
//             Valid mode: iy=oy+ky, ix=ox+kx.
//             Last tap -> WRITE.
//    WRITE    writes sat(acc>>>S) to C + oy*OW + ox; clears acc; -> PIX_RD for the next output, ox fastest;
//             after the last output -> DONE.
//    DONE     pulses done, clears busy -> IDLE.
//    ERR      sets error, pulses done, clears busy -> IDLE. No write is issued.
//  Output size: valid mode OW=W-K+1, OH=H-K+1.
//  Arithmetic: full-precision signed product, sign-extended to ACC_W.
//    Arithmetic right shift by S, then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Boundary conditions:
//    - start while busy: ignored.
//    - abort and start in the same cycle: abort wins.
//    - abort: next cycle mem_operation=00, busy=0, no done pulse; partial outputs stay in memory.
//    - K==1: one tap per output, copy with shift and saturate.
//    - Address arithmetic: ADDR_W wide, wraps modulo 2^ADDR_W.
// CONFIGURATION
//  CONV_ZERO_PAD_EN defined:
//    - P+5 bit0 = mode (0 valid, 1 same); P+5 is read after P+4, so PARAM_RD performs 5 reads.
//    - Same mode: OW=W, OH=H, iy=oy+ky-(K-1)/2, ix=ox+kx-(K-1)/2.
//    - Out-of-range taps contribute 0, take 1 cycle, and issue no bus read.
//    - Same mode skips the K>W/K>H check.
//  Not defined: valid mode only; P+5 is never read; no padding logic.
// TESTING
//  1. W=4,H=4,K=3,S=0, A=1..16, kernel all 1 -> writes 54,63,90,99 to 31,32,33,34; done pulse, error=0.
//  2. K=4 (also K=7 with KMAX=5) -> error=1, done pulse, zero write transactions after the 4 param reads.
//  3. W=H=3,K=3, A all 0x7FFFFFFF, kernel all 1, S=0 -> one write of 0x7FFFFFFF. Same data with kernel all -1 -> 0x80000000.
//  4. S=2, image of 8s, 1x1 kernel of 3 -> every output 6; mem_opdone delayed 0..5 random cycles -> identical results.
//  5. CONV_ZERO_PAD_EN, mode=1, 3x3 ones image, 3x3 ones kernel -> 9 writes: corners 4, edges 6, centre 9.
//     Macro undefined -> 1 write of 9.
//  6. abort during KERN_LD -> mem_operation=00 and busy=0 next cycle, no done. Then start -> full correct run.
//     reset low during WRITE -> outputs 0 immediately.

Source files
------------

// File: rtl/conv2d_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv2d_engine
//  Purpose  : Parametrised 2-D convolution engine on a single-port word bus.
//             Fetches W/H/K/S from a parameter block, caches the KxK kernel,
//             streams image taps into a wide signed accumulator and writes
//             sat(acc >>> S) for every output pixel (row-major, ox fastest).
//  Ports    : clk, reset (async, active-low)
//             start (pulse), abort (level)
//             mem_opdone, data_i            - bus completion / read data
//             data_o, addr_o, mem_operation - bus request (00 none/01 rd/11 wr)
//             busy, done (pulse), error (sticky until next start)
//  Options  : CONV_ZERO_PAD_EN - adds "same" mode (P+5 bit0) with zero padding
//  Revision : 1.0 - initial release
// ============================================================================
module conv2d_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int KMAX       = 5,
  parameter int ACC_W      = 72,
  parameter int PARAM_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int KK_MAX = KMAX * KMAX;
  localparam int TAP_W  = (KK_MAX > 1) ? $clog2(KK_MAX) : 1;
`ifdef CONV_ZERO_PAD_EN
  localparam int NPARAM = 5;
`else
  localparam int NPARAM = 4;
`endif
  localparam logic [1:0]        c_OP_NONE = 2'b00;
  localparam logic [1:0]        c_OP_RD   = 2'b01;
  localparam logic [1:0]        c_OP_WR   = 2'b11;
  localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_P1      = ADDR_W'(PARAM_BASE + 1);
  localparam logic [ADDR_W-1:0] c_A       = ADDR_W'(PARAM_BASE + 6);
  localparam logic [ADDR_W-1:0] c_KMAX    = ADDR_W'(KMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM_RD, S_CHECK, S_KERN_LD, S_PIX_RD, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                    r_state;
  logic [1:0]                r_op;
  logic [ADDR_W-1:0]         r_addr;
  logic [DATA_W-1:0]         r_wdata;
  logic                      r_busy, r_done, r_error;
  logic [2:0]                r_pidx;
  logic [ADDR_W-1:0]         r_w, r_h, r_k;
  logic [5:0]                r_s;
  logic [TAP_W-1:0]          r_tap;
  logic [ADDR_W-1:0]         r_kx, r_ky, r_ox, r_oy;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_cache [KK_MAX];
`ifdef CONV_ZERO_PAD_EN
  logic                      r_mode;
`endif

  // Derived geometry; all address math wraps modulo 2^ADDR_W.
  logic [ADDR_W-1:0] w_kk, w_kb, w_c, w_ow, w_oh, w_ysum, w_xsum, w_iy, w_ix;
  logic [ADDR_W-1:0] w_pix_addr, w_out_addr;
  logic              w_in_range, w_bad, w_last_tap, w_kx_last, w_ox_last, w_last_out;

  assign w_kk   = r_k * r_k;
  assign w_kb   = c_A + r_w * r_h;
  assign w_c    = w_kb + w_kk;
  assign w_ysum = r_oy + r_ky;
  assign w_xsum = r_ox + r_kx;

`ifdef CONV_ZERO_PAD_EN
  logic [ADDR_W-1:0] w_pad;
  assign w_pad      = r_mode ? ((r_k - c_ONE) >> 1) : '0;
  assign w_ow       = r_mode ? r_w : (r_w - r_k + c_ONE);
  assign w_oh       = r_mode ? r_h : (r_h - r_k + c_ONE);
  assign w_iy       = w_ysum - w_pad;
  assign w_ix       = w_xsum - w_pad;
  // A tap outside the image is skipped (contributes zero, no bus read).
  assign w_in_range = (w_ysum >= w_pad) && (w_iy < r_h) &&
                      (w_xsum >= w_pad) && (w_ix < r_w);
  assign w_bad      = ~r_k[0] | (r_k > c_KMAX) | (r_w == '0) | (r_h == '0) |
                      (~r_mode & ((r_k > r_w) | (r_k > r_h)));
`else
  assign w_ow       = r_w - r_k + c_ONE;
  assign w_oh       = r_h - r_k + c_ONE;
  assign w_iy       = w_ysum;
  assign w_ix       = w_xsum;
  assign w_in_range = 1'b1;
  // K even also covers K==0.
  assign w_bad      = ~r_k[0] | (r_k > c_KMAX) | (r_w == '0) | (r_h == '0) |
                      (r_k > r_w) | (r_k > r_h);
`endif

  assign w_pix_addr = c_A + w_iy * r_w + w_ix;
  assign w_out_addr = w_c + r_oy * w_ow + r_ox;
  assign w_last_tap = (ADDR_W'(r_tap) == (w_kk - c_ONE));
  assign w_kx_last  = (r_kx == (r_k - c_ONE));
  assign w_ox_last  = (r_ox == (w_ow - c_ONE));
  assign w_last_out = w_ox_last && (r_oy == (w_oh - c_ONE));

  // Full-precision product, sign-extended into the accumulator.
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_shift;
  logic [ACC_W-DATA_W:0]      w_hi;
  logic                       w_fits;
  logic [DATA_W-1:0]          w_sat;

  assign w_prod     = $signed(data_i) * r_cache[r_tap];
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_shift    = r_acc >>> r_s;
  // Value fits in DATA_W iff every bit from the DATA_W sign bit upward agrees.
  assign w_hi       = w_shift[ACC_W-1:DATA_W-1];
  assign w_fits     = (&w_hi) | ~(|w_hi);
  assign w_sat      = w_fits ? w_shift[DATA_W-1:0] :
                      (w_shift[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= c_OP_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_pidx  <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_k     <= '0;
      r_s     <= '0;
      r_tap   <= '0;
      r_kx    <= '0;
      r_ky    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_acc   <= '0;
      for (int i = 0; i < KK_MAX; i++) r_cache[i] <= '0;
`ifdef CONV_ZERO_PAD_EN
      r_mode  <= 1'b0;
`endif
    end else if (abort) begin
      r_state <= S_IDLE;
      r_op    <= c_OP_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_done <= 1'b0;
      // Every bus state: issue when idle, retire on opdone. Retiring drops
      // r_op for a cycle, which gives the mandatory idle cycle between ops.
      case (r_state)
        S_IDLE: if (start) begin
          r_busy  <= 1'b1;
          r_error <= 1'b0;
          r_pidx  <= '0;
          r_acc   <= '0;
          r_state <= S_PARAM_RD;
        end
        S_PARAM_RD: begin
          if (r_op == c_OP_NONE) begin
            r_op   <= c_OP_RD;
            r_addr <= c_P1 + ADDR_W'(r_pidx);
          end else if (mem_opdone) begin
            r_op <= c_OP_NONE;
            case (r_pidx)
              3'd0:    r_w <= ADDR_W'(data_i);
              3'd1:    r_h <= ADDR_W'(data_i);
              3'd2:    r_k <= ADDR_W'(data_i);
              3'd3:    r_s <= data_i[5:0];
`ifdef CONV_ZERO_PAD_EN
              default: r_mode <= data_i[0];
`else
              default: ;
`endif
            endcase
            if (r_pidx == 3'(NPARAM-1)) r_state <= S_CHECK;
            else                        r_pidx  <= r_pidx + 3'd1;
          end
        end
        S_CHECK: begin
          r_tap   <= '0;
          r_kx    <= '0;
          r_ky    <= '0;
          r_ox    <= '0;
          r_oy    <= '0;
          r_state <= w_bad ? S_ERR : S_KERN_LD;
        end
        S_KERN_LD: begin
          if (r_op == c_OP_NONE) begin
            r_op   <= c_OP_RD;
            r_addr <= w_kb + ADDR_W'(r_tap);
          end else if (mem_opdone) begin
            r_op           <= c_OP_NONE;
            r_cache[r_tap] <= $signed(data_i);
            if (w_last_tap) begin
              r_tap   <= '0;
              r_state <= S_PIX_RD;
            end else begin
              r_tap <= r_tap + TAP_W'(1);
            end
          end
        end
        S_PIX_RD: begin
          if (r_op == c_OP_NONE && w_in_range) begin
            r_op   <= c_OP_RD;
            r_addr <= w_pix_addr;
          end else if (r_op == c_OP_NONE || mem_opdone) begin
            // Either a completed read or a padded tap: step to the next tap.
            if (r_op != c_OP_NONE) begin
              r_op  <= c_OP_NONE;
              r_acc <= r_acc + w_prod_ext;
            end
            if (w_last_tap) begin
              r_tap   <= '0;
              r_kx    <= '0;
              r_ky    <= '0;
              r_state <= S_WRITE;
            end else begin
              r_tap <= r_tap + TAP_W'(1);
              if (w_kx_last) begin
                r_kx <= '0;
                r_ky <= r_ky + c_ONE;
              end else begin
                r_kx <= r_kx + c_ONE;
              end
            end
          end
        end
        S_WRITE: begin
          if (r_op == c_OP_NONE) begin
            r_op    <= c_OP_WR;
            r_addr  <= w_out_addr;
            r_wdata <= w_sat;
          end else if (mem_opdone) begin
            r_op  <= c_OP_NONE;
            r_acc <= '0;
            if (w_last_out) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_PIX_RD;
              if (w_ox_last) begin
                r_ox <= '0;
                r_oy <= r_oy + c_ONE;
              end else begin
                r_ox <= r_ox + c_ONE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_o        = r_wdata;
  assign addr_o        = r_addr;
  assign mem_operation = r_op;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv2d_engine
//  Purpose  : Directed self-checking bench for conv2d_engine with a simple
//             word-memory bus responder (optional random opdone latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_engine;
`ifdef CONV_ZERO_PAD_EN
  localparam int NPARAM = 5;
`else
  localparam int NPARAM = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mem_opdone = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [31:0] addr_o;
  logic [1:0]  mem_operation;
  logic        busy, done, error;

  logic [31:0] mem [0:63];
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, max_delay = 0;
  int n_checks = 0, n_fail = 0;

  conv2d_engine #(.DATA_W(32), .ADDR_W(32), .KMAX(5), .ACC_W(72), .PARAM_BASE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mem_opdone(mem_opdone), .data_i(data_i), .data_o(data_o), .addr_o(addr_o),
    .mem_operation(mem_operation), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus responder: completes each transfer after 0..max_delay cycles.
  initial begin : responder
    int wait_left;
    wait_left = -1;
    forever begin
      @(negedge clk);
      if (mem_opdone) begin
        mem_opdone = 1'b0;
        wait_left  = -1;
      end else if (reset && mem_operation != 2'b00) begin
        if (wait_left < 0) wait_left = int'($urandom_range(max_delay, 0));
        if (wait_left == 0) begin
          if (mem_operation == 2'b11) begin
            mem[addr_o[5:0]] = data_o;
            wr_cnt++;
          end else begin
            data_i = mem[addr_o[5:0]];
            rd_cnt++;
          end
          mem_opdone = 1'b1;
          wait_left  = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic set_params(input int w, input int h, input int k, input int s, input int mode);
    mem[1] = 32'(w); mem[2] = 32'(h); mem[3] = 32'(k); mem[4] = 32'(s); mem[5] = 32'(mode);
  endtask

  task automatic fill(input int base, input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) mem[base+i] = v;
  endtask

  // Pulse start, wait for done (bounded); optionally re-pulse start mid-run.
  task automatic run_conv(input string tag, input int restart_at);
    int  d0;
    bit  got;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " busy_set"}, 32'(busy), 32'd1);
    chk({tag, " err_clr"}, 32'(error), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      if (done_cnt != d0) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, " one_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, " busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int w0, r0, d0;
    bit got;
    logic [31:0] pad_exp [0:8];
    pad_exp[0] = 4; pad_exp[1] = 6; pad_exp[2] = 4;
    pad_exp[3] = 6; pad_exp[4] = 9; pad_exp[5] = 6;
    pad_exp[6] = 4; pad_exp[7] = 6; pad_exp[8] = 4;
    clear_mem();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ctl", 32'({mem_operation, busy, done, error}), 32'd0);
    chk("rst addr", addr_o, 32'd0);
    chk("rst data", data_o, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 4x4 ramp, 3x3 ones -> 54,63,90,99 at 31..34
    clear_mem(); set_params(4, 4, 3, 0, 0);
    for (int i = 0; i < 16; i++) mem[6+i] = 32'(i + 1);
    fill(22, 9, 32'd1);
    w0 = wr_cnt;
    run_conv("t1", -1);
    chk("t1 o0", mem[31], 32'd54);
    chk("t1 o1", mem[32], 32'd63);
    chk("t1 o2", mem[33], 32'd90);
    chk("t1 o3", mem[34], 32'd99);
    chk("t1 writes", 32'(wr_cnt - w0), 32'd4);
    chk("t1 error", 32'(error), 32'd0);

    // 2: bad K -> error, no writes, only parameter reads
    set_params(4, 4, 4, 0, 0);
    w0 = wr_cnt; r0 = rd_cnt;
    run_conv("t2a", -1);
    chk("t2a error", 32'(error), 32'd1);
    chk("t2a writes", 32'(wr_cnt - w0), 32'd0);
    chk("t2a reads", 32'(rd_cnt - r0), 32'(NPARAM));
    set_params(8, 8, 7, 0, 0);
    w0 = wr_cnt; r0 = rd_cnt;
    run_conv("t2b", -1);
    chk("t2b error", 32'(error), 32'd1);
    chk("t2b writes", 32'(wr_cnt - w0), 32'd0);
    chk("t2b reads", 32'(rd_cnt - r0), 32'(NPARAM));
    repeat (5) @(negedge clk);
    chk("err sticky", 32'(error), 32'd1);

    // abort and start together: abort wins, error stays set, no bus activity
    r0 = rd_cnt;
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort+start busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort+start err", 32'(error), 32'd1);
    chk("abort+start reads", 32'(rd_cnt - r0), 32'd0);

    // 3: saturation both ways
    clear_mem(); set_params(3, 3, 3, 0, 0);
    fill(6, 9, 32'h7FFF_FFFF); fill(15, 9, 32'd1);
    w0 = wr_cnt;
    run_conv("t3a", -1);
    chk("t3a pos sat", mem[24], 32'h7FFF_FFFF);
    chk("t3a writes", 32'(wr_cnt - w0), 32'd1);
    fill(15, 9, 32'hFFFF_FFFF); mem[24] = '0;
    run_conv("t3b", -1);
    chk("t3b neg sat", mem[24], 32'h8000_0000);

    // 4: K=1 copy with shift, then random bus latency plus a start while busy
    clear_mem(); set_params(3, 2, 1, 2, 0);
    fill(6, 6, 32'd8); mem[12] = 32'd3;
    run_conv("t4a", -1);
    for (int i = 0; i < 6; i++) chk($sformatf("t4a o%0d", i), mem[13+i], 32'd6);
    fill(13, 6, 32'd0);
    max_delay = 5; w0 = wr_cnt;
    run_conv("t4b", 20);
    for (int i = 0; i < 6; i++) chk($sformatf("t4b o%0d", i), mem[13+i], 32'd6);
    chk("t4b writes", 32'(wr_cnt - w0), 32'd6);
    fill(6, 6, 32'hFFFF_FFF8); fill(13, 6, 32'd0);
    run_conv("t4c", -1);
    for (int i = 0; i < 6; i++) chk($sformatf("t4c o%0d", i), mem[13+i], 32'hFFFF_FFFA);
    max_delay = 0;

    // 5: 3x3 ones image and kernel, mode word = 1
    clear_mem(); set_params(3, 3, 3, 0, 1);
    fill(6, 9, 32'd1); fill(15, 9, 32'd1);
    w0 = wr_cnt;
    run_conv("t5", -1);
`ifdef CONV_ZERO_PAD_EN
    chk("t5 writes", 32'(wr_cnt - w0), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("t5 o%0d", i), mem[24+i], pad_exp[i]);
`else
    chk("t5 writes", 32'(wr_cnt - w0), 32'd1);
    chk("t5 o0", mem[24], 32'd9);
    chk("t5 o1 untouched", mem[25], 32'd0);
`endif

    // 6: abort during kernel load, then a clean rerun
    clear_mem(); set_params(4, 4, 3, 0, 0);
    for (int i = 0; i < 16; i++) mem[6+i] = 32'(i + 1);
    fill(22, 9, 32'd1);
    r0 = rd_cnt; d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rd_cnt - r0 >= NPARAM + 2) got = 1'b1;
    end
    chk("t6 reached kern_ld", 32'(got), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    chk("t6 abort op", 32'(mem_operation), 32'd0);
    chk("t6 abort busy", 32'(busy), 32'd0);
    abort = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6 no done", 32'(done_cnt - d0), 32'd0);
    chk("t6 idle op", 32'(mem_operation), 32'd0);
    run_conv("t6r", -1);
    chk("t6r o0", mem[31], 32'd54);
    chk("t6r o3", mem[34], 32'd99);

    // reset asserted while a write is outstanding
    fill(31, 4, 32'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (mem_operation == 2'b11) got = 1'b1;
    end
    chk("t7 reached write", 32'(got), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t7 rst ctl", 32'({mem_operation, busy, done, error}), 32'd0);
    chk("t7 rst addr", addr_o, 32'd0);
    chk("t7 rst data", data_o, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    fill(31, 4, 32'd0);
    run_conv("t7r", -1);
    chk("t7r o1", mem[32], 32'd63);
    chk("t7r o2", mem[33], 32'd90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
